// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps one instruction-memory request in
// flight and feeds decode through the IF/ID register, backed by a one-entry hold buffer.
module fetch_stage #(
    parameter int unsigned     PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            misalign_err
);
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [31:0]     NOP_INSTR   = 32'h0000_0013;
    localparam logic [PC_W-1:0] PC_STEP     = PC_W'(3'd4);
    localparam logic [PC_W-1:0] RESET_PC_AL = {RESET_PC[PC_W-1:2], 2'b00};

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    logic [PC_W-1:0] buf_pc_q, buf_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic            misalign_q, misalign_d;
    logic            req_q, req_d;

    logic            gnt_s;
    logic            accept_s;
    logic            load_s;
    logic [PC_W-1:0] load_pc_s;
    logic [31:0]     load_instr_s;
    logic [PC_W-1:0] target_s;
    logic            unused_s;

    assign gnt_s    = req_q & imem_gnt;
    assign accept_s = ~stall | ~id_valid_q;
    assign target_s = {BrPC[PC_W-1:2], 2'b00};
    assign unused_s = ^BrPC;

    // Next-state, fetch-request and IF/ID update logic; a redirect overrides everything else.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        misalign_d   = 1'b0;
        load_s       = 1'b0;
        load_pc_s    = req_pc_q;
        load_instr_s = imem_rdata;
        if (PcSel) begin
            pc_d       = target_s;
            id_valid_d = 1'b0;
            misalign_d = (BrPC[1:0] != 2'b00);
            case (state_q)
                S_FETCH: state_d = gnt_s ? S_DRAIN : S_FETCH;
                S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                S_HOLD:  state_d = S_FETCH;
                S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (gnt_s) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = S_WAIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid && accept_s) begin
                        load_s  = 1'b1;
                        state_d = S_FETCH;
                    end else if (imem_rvalid) begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = req_pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (accept_s) begin
                        load_s       = 1'b1;
                        load_pc_s    = buf_pc_q;
                        load_instr_s = buf_instr_q;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
            if (load_s) begin
                id_valid_d = 1'b1;
                id_pc_d    = load_pc_s;
                id_instr_d = load_instr_s;
            end else if (!stall) begin
                id_valid_d = 1'b0;
            end else begin
                id_valid_d = id_valid_q;
            end
        end
        req_d = (state_d == S_FETCH);
    end

    // State, PC, hold buffer and IF/ID registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC_AL;
            req_pc_q    <= {PC_W{1'b0}};
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= {PC_W{1'b0}};
            id_valid_q  <= 1'b0;
            id_pc_q     <= {PC_W{1'b0}};
            id_instr_q  <= NOP_INSTR;
            misalign_q  <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
            misalign_q  <= misalign_d;
            req_q       <= req_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_instr     = id_instr_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a randomized memory responder plus a transaction-level model of the
// fetch stream (expected PC, granted-not-delivered addresses, words waiting for decode).
module tb_fetch_stage;
    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset, stall, PcSel, imem_gnt, imem_rvalid;
    logic [31:0]     BrPC, imem_rdata, id_instr;
    logic            imem_req, id_valid, misalign_err;
    logic [PC_W-1:0] imem_addr, id_pc;

    int total = 0;
    int bad   = 0;

    logic [PC_W-1:0] exp_pc;
    logic [PC_W-1:0] dq[$];
    int              ready_n;
    logic            busy, stale;
    int              cnt;
    logic [PC_W-1:0] rsp_addr;
    int              lat_lo, lat_hi;
    logic [31:0]     salt;

    logic            p_req, p_gnt, p_rv, p_st, p_ps, p_idv;
    logic [31:0]     p_br, p_instr;
    logic [PC_W-1:0] p_addr, p_pc;

    fetch_stage #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .PcSel(PcSel), .BrPC(BrPC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return salt ^ {23'h0, a};
    endfunction

    task automatic model_reset();
        exp_pc   = 9'h000;
        dq.delete();
        ready_n  = 0;
        busy     = 1'b0;
        stale    = 1'b0;
        cnt      = 0;
        rsp_addr = 9'h000;
    endtask

    // Advance the model over the edge just taken and compare against the DUT outputs.
    task automatic model_step();
        if (p_rv && busy) begin
            busy = 1'b0;
            if (!stale && !p_ps) ready_n++;
        end else if (busy) begin
            cnt--;
        end
        if (p_req && p_gnt) begin
            check_eq("gnt_addr", p_addr, exp_pc);
            if (!p_ps) dq.push_back(exp_pc);
            rsp_addr = p_addr;
            busy     = 1'b1;
            stale    = 1'b0;
            cnt      = $urandom_range(lat_hi, lat_lo) - 1;
            exp_pc   = exp_pc + 9'd4;
        end
        if (p_ps) begin
            exp_pc  = {p_br[PC_W-1:2], 2'b00};
            dq.delete();
            ready_n = 0;
            if (busy) stale = 1'b1;
        end

        check_eq("misalign", misalign_err, p_ps && (p_br[1:0] != 2'b00));
        if (p_ps) begin
            check_eq("flush_valid", id_valid, 1'b0);
            check_eq("flush_pc", id_pc, p_pc);
        end else if (p_idv && p_st) begin
            check_eq("hold_valid", id_valid, 1'b1);
            check_eq("hold_pc", id_pc, p_pc);
            check_eq("hold_instr", id_instr, p_instr);
        end else if (ready_n > 0 && dq.size() > 0) begin
            check_eq("load_valid", id_valid, 1'b1);
            check_eq("load_pc", id_pc, dq[0]);
            check_eq("load_instr", id_instr, mem_word(dq[0]));
            void'(dq.pop_front());
            ready_n--;
        end else begin
            check_eq("idle_valid", id_valid, 1'b0);
            check_eq("idle_pc", id_pc, p_pc);
            check_eq("idle_instr", id_instr, p_instr);
        end
        check_eq("req", imem_req, (!busy && ready_n == 0));
        if (imem_req) check_eq("addr", imem_addr, exp_pc);
    endtask

    task automatic run_cycle(input logic st, input logic ps, input logic [31:0] br,
                             input logic gn, input logic force_rv);
        stall       = st;
        PcSel       = ps;
        BrPC        = br;
        imem_gnt    = gn;
        imem_rvalid = (busy && cnt == 0) || force_rv;
        imem_rdata  = (busy && cnt == 0) ? mem_word(rsp_addr) : $urandom();
        p_req   = imem_req;
        p_addr  = imem_addr;
        p_gnt   = gn;
        p_rv    = imem_rvalid;
        p_st    = st;
        p_ps    = ps;
        p_br    = br;
        p_idv   = id_valid;
        p_pc    = id_pc;
        p_instr = id_instr;
        @(posedge clk);
        @(negedge clk);
        model_step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, imem_req, 1'b0);
        check_eq({tag, "_addr"}, imem_addr, 9'h000);
        check_eq({tag, "_valid"}, id_valid, 1'b0);
        check_eq({tag, "_pc"}, id_pc, 9'h000);
        check_eq({tag, "_instr"}, id_instr, 32'h0000_0013);
        check_eq({tag, "_mis"}, misalign_err, 1'b0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; PcSel = 1'b0; BrPC = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        salt = 32'h0; lat_lo = 1; lat_hi = 1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        #1 check_eq("req_after_release", imem_req, 1'b0);

        // Zero-wait sequential fetch: IF/ID shows pc 0, 4, 8 two cycles apart.
        for (int i = 0; i < 7; i++) begin
            run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            if (i == 2 || i == 4 || i == 6) begin
                check_eq("seq_valid", id_valid, 1'b1);
                check_eq("seq_pc", id_pc, 9'((i - 2) * 2));
                check_eq("seq_instr", id_instr, 32'((i - 2) * 2));
            end
        end

        run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("stall_req", imem_req, 1'b0);
        check_eq("stall_pc", id_pc, 9'h008);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("unstall_pc", id_pc, 9'h00C);
        check_eq("unstall_addr", imem_addr, 9'h010);

        run_cycle(1'b0, 1'b1, 32'h0000_01FC, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("wrap_pc", id_pc, 9'h1FC);
        check_eq("wrap_addr", imem_addr, 9'h000);

        run_cycle(1'b0, 1'b1, 32'h0000_0023, 1'b1, 1'b0);
        check_eq("mis_pulse", misalign_err, 1'b1);
        check_eq("mis_req", imem_req, 1'b0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("mis_gone", misalign_err, 1'b0);
        check_eq("drain_addr", imem_addr, 9'h020);
        check_eq("drain_valid", id_valid, 1'b0);

        // Async reset while a request is outstanding.
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20 && !(busy && cnt >= 1); i++)
            run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("reach_wait", busy && cnt >= 1, 1'b1);
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("arst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("late_rv_valid", id_valid, 1'b0);
        check_eq("restart_addr", imem_addr, 9'h000);

        salt = $urandom(); lat_lo = 1; lat_hi = 3;
        for (int n = 0; n < 3000; n++)
            run_cycle($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 6, $urandom(),
                      $urandom_range(99, 0) < 70, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I pipeline. It owns the program counter, issues one outstanding request at a time to instruction memory, and delivers {pc, instruction} to decode through the IF/ID register. It consumes the branch unit's `PcSel`/`BrPC` redirect and flushes wrong-path work. It honours the hazard unit's `stall`.

## Interface
Parameters:
- `PC_W`, default 9: PC and instruction-address width in bits; byte addresses.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode cannot accept; IF/ID holds its contents.
- `PcSel`  in  1  redirect request from the branch unit; 1 = taken.
- `BrPC`  in  32  redirect target; only bits `[PC_W-1:0]` are used.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  PC_W  fetch byte address; bits [1:0] are always 0.
- `imem_gnt`  in  1  memory accepts the request this cycle (`req && gnt`).
- `imem_rvalid`  in  1  read data valid; the earliest legal assertion is the cycle after the grant.
- `imem_rdata`  in  32  instruction word.
- `id_valid`  out  1  IF/ID holds a valid instruction.
- `id_pc`  out  PC_W  PC of the IF/ID instruction.
- `id_instr`  out  32  IF/ID instruction.
- `misalign_err`  out  1  one-cycle pulse when a redirect target has nonzero bits [1:0].

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_pc`: address of the outstanding request.
  - `buf_instr`/`buf_pc`: one-entry hold buffer.
  - IF/ID register: `id_valid`, `id_pc`, `id_instr`.
  - FSM state.
- FSM states and behaviour:
  - **FETCH**:
    - `imem_req=1`, `imem_addr=pc`.
    - On `imem_gnt`: `req_pc<=pc`, `pc<=pc+4` (mod 2^PC_W, wraps to 0), go to WAIT.
  - **WAIT**:
    - `imem_req=0`; waits for `imem_rvalid`.
    - If IF/ID can accept (`!stall`): load IF/ID with {`req_pc`, `imem_rdata`}, `id_valid<=1`, go to FETCH.
    - Otherwise: capture the word into the buffer and go to HOLD.
  - **HOLD**:
    - `imem_req=0`.
    - When `!stall`: move the buffer into IF/ID, `id_valid<=1`, go to FETCH.
  - **DRAIN**:
    - `imem_req=0`; discards the stale in-flight response.
    - On `imem_rvalid`: drop the data and go to FETCH.
- IF/ID update when `!stall` and no new word is available: `id_valid<=0`. `id_pc`/`id_instr` keep their values.
- Redirect (`PcSel=1`) has priority over `stall` and over all FSM actions:
  - `pc <= {BrPC[PC_W-1:2], 2'b00}`.
  - `id_valid<=0`; the buffer is invalidated.
  - `misalign_err<=1` for one cycle if `BrPC[1:0]!=0`.
  - Next state:
    - FETCH with `imem_gnt` in the same cycle → DRAIN, because a request at the old PC is in flight.
    - FETCH without grant → FETCH.
    - WAIT without `imem_rvalid` → DRAIN.
    - WAIT with `imem_rvalid` in the same cycle → FETCH; the data is discarded.
    - HOLD → FETCH.
    - DRAIN → DRAIN, unless `imem_rvalid` arrives in the same cycle, in which case → FETCH.
- `stall` while `id_valid=0`: IF/ID may still be loaded, since an empty slot always accepts. Only a valid, stalled IF/ID blocks loading.

## Timing
- Reset values:
  - `pc=RESET_PC`, state FETCH.
  - `id_valid=0`, `id_pc=0`, `id_instr=32'h0000_0013` (NOP).
  - `misalign_err=0`, `req_pc=0`, buffer empty.
- While `reset=0`, `imem_req=0`. `imem_req=1` from the first clock edge after deassertion.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). Any response arriving afterwards is ignored until a new grant.
- Latency with zero-wait memory (grant in the request cycle, rvalid the next cycle): an instruction is visible in IF/ID 2 cycles after its request cycle.
- Throughput is one instruction per 2 cycles; there is only one outstanding request.
- A redirect in cycle N means the fetch of the target is requested in cycle N+1 (from FETCH), or in the cycle after the drain completes.
- `id_valid` is 0 in cycle N+1 after a redirect in cycle N.
- `imem_addr` is a registered value, stable whenever `imem_req=1`.

## Test plan
- **Reset and sequential fetch:** release reset; memory has zero wait and returns `addr` as data → IF/ID shows (pc 0, instr 0), (4, 4), (8, 8) on cycles 2, 4, 6; `imem_addr` steps 0, 4, 8.
- **Stall/hold:**
  - Setup: `stall=1` while IF/ID holds pc 4, and the response for pc 8 arrives.
  - While stalled: FSM goes to HOLD; IF/ID stays at pc 4; `imem_req=0`.
  - Release `stall`: IF/ID shows pc 8 next cycle; then the request to 12 is issued.
- **Redirect during WAIT:**
  - Stimulus: `PcSel=1`, `BrPC=0x40` while WAIT at pc 8, with rvalid arriving 2 cycles later.
  - Required: `id_valid=0`; the stale word is dropped in DRAIN; the next request address is 0x40; IF/ID next valid shows pc 0x40.
- **Redirect with simultaneous grant, plus misalignment:**
  - Stimulus: `PcSel=1`, `BrPC=0x23` in a FETCH cycle with grant.
  - Required: `misalign_err` pulses once; DRAIN consumes one response; then a request to 0x20 is issued.
- **Wrap-around and redirect-over-stall:**
  - Wrap: with `PC_W=9`, pc 0x1FC is granted, then the next request is to 0x000.
  - Redirect-over-stall: `PcSel=1` with `stall=1` still flushes IF/ID (`id_valid=0`).
- **Async reset mid-WAIT:** assert `reset=0` for one cycle → outputs return to reset values without waiting for a clock edge; a late rvalid is ignored; fetch restarts at `RESET_PC`.
